ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-002 SHALL have port ex_valid in 1: execute result valid this cycle.
REQ-003 SHALL have port ex_ready out 1: register can accept the execute result.
REQ-004 SHALL have ports alu_result in data_t, rd_wren in 1: execute-stage outputs.
REQ-005 SHALL have ports pc in data_t, rs2 in data_t (store data), instr in instr_t.
REQ-006 SHALL have port flush in 1: discard all held and incoming entries.
REQ-007 SHALL have ports mem_valid out 1, mem_ready in 1: downstream handshake.
REQ-008 SHALL have ports mem_alu_result, mem_pc, mem_rs2 out data_t; mem_instr out instr_t; mem_rd_wren out 1.
REQ-009 SHALL have ports ex_ex_fwd_data out data_t, fwd_rd out 5, fwd_valid out 1: forwarding source for execute.

Function
REQ-010 SHALL accept an entry on a rising clk edge when ex_valid && ex_ready, and SHALL complete a transfer when mem_valid && mem_ready.
REQ-011 SHALL provide one-cycle latency: an accepted entry appears on mem_* on the next cycle when the output slot is empty or draining.
REQ-012 SHALL hold mem_* stable while mem_valid && !mem_ready.
REQ-013 SHALL implement states EMPTY, FULL and SKID (SKID only when EX_MEM_SKID_EN is defined).
REQ-014 EMPTY->FULL on accept; FULL->EMPTY on transfer without accept; FULL stays FULL on simultaneous accept and transfer.
REQ-015 FULL->SKID on accept without transfer; SKID->FULL on transfer, with the skid entry moving to the output slot on the same edge.
REQ-016 In SKID, SHALL deassert ex_ready; the incoming entry SHALL NOT be accepted.
REQ-017 flush SHALL force EMPTY on the next edge, take priority over accept and transfer, and drop the incoming entry.
REQ-018 SHALL drive ex_ex_fwd_data = mem_alu_result and fwd_rd = mem_instr rd field.
REQ-019 SHALL drive fwd_valid = mem_valid && mem_rd_wren && (fwd_rd != 0).
REQ-020 SHALL keep entry fields unchanged when moving between slots; there SHALL be no arithmetic or width conversion.

Reset
REQ-021 rst_n low SHALL immediately, asynchronously, force EMPTY, mem_valid=0 and fwd_valid=0.
REQ-022 On reset, data outputs SHALL be 0, mem_rd_wren SHALL be 0, and mem_instr SHALL be NOP (0x00000013).
REQ-023 ex_ready SHALL be 1 out of reset.
REQ-024 Assertion mid-transfer SHALL discard all held entries with no partial output.

Configuration
REQ-025 With EX_MEM_SKID_EN defined: two slots (output plus skid); ex_ready SHALL be a registered signal, = state != SKID.
REQ-026 Without EX_MEM_SKID_EN: single slot, no SKID state; ex_ready SHALL be combinational, = !mem_valid || mem_ready.

Structure
REQ-027 data_t, instr_t, the NOP constant and the state enum type SHALL live in the shared defines package.
REQ-028 The skid slot SHALL be a sub-module, ex_mem_slot: one registered entry with load and clear inputs, instantiated once or twice.
REQ-029 The block SHALL sit between execute and the memory stage, and SHALL feed execute's ex_ex_fwd_data input.

Verification
REQ-030 Reset then ex_valid=1 with alu_result=0x0000_1234 and mem_ready=1 -> next cycle mem_valid=1, mem_alu_result=0x1234, ex_ready=1.
REQ-031 mem_ready=0 with two accepts, alu_result=0xA then 0xB (SKID_EN) -> ex_ready=0, output holds 0xA; after mem_ready=1 the sequence 0xA, 0xB emerges.
REQ-032 flush=1 in SKID with ex_valid=1 -> next cycle mem_valid=0, ex_ready=1, and no further output occurs.
REQ-033 Held instruction with rd=0 and rd_wren=1 -> fwd_valid=0; with rd=5 -> fwd_valid=1, fwd_rd=5.
REQ-034 rst_n low mid-stall -> mem_valid=0 in the same cycle, mem_instr=0x00000013.
REQ-035 Without EX_MEM_SKID_EN, mem_valid=1 and mem_ready=0 -> ex_ready=0 combinationally; setting mem_ready=1 -> ex_ready=1 in the same cycle.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// Shared types for the EX/MEM pipeline register.
// EX_MEM_SKID_EN adds the SKID state to the state enum.
package ex_mem_reg_pkg;

   typedef logic [31:0] data_t;
   typedef logic [31:0] instr_t;

   localparam instr_t NOP = 32'h0000_0013;

`ifdef EX_MEM_SKID_EN
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1
   } state_e;
`endif

   typedef struct packed {
      data_t  alu_result;
      data_t  pc;
      data_t  rs2;
      instr_t instr;
      logic   rd_wren;
   } entry_t;

   localparam entry_t ENTRY_RST = '{
      alu_result: 32'h0,
      pc:         32'h0,
      rs2:        32'h0,
      instr:      NOP,
      rd_wren:    1'b0
   };

   function automatic logic [4:0] rd_of(input instr_t i);
      return i[11:7];
   endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One registered EX/MEM entry with load and clear.
// Clear wins over load and restores the reset entry.
module ex_mem_slot
   import ex_mem_reg_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load_i,
   input  logic   clear_i,
   input  entry_t d_i,
   output entry_t q_o
);

   entry_t entry_q;
   entry_t entry_d;

   // Next entry: clear, load or hold.
   always_comb begin
      entry_d = entry_q;
      if (clear_i) begin
         entry_d = ENTRY_RST;
      end else if (load_i) begin
         entry_d = d_i;
      end
   end

   // Entry register, reset to a NOP bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= ENTRY_RST;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign q_o = entry_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with valid/ready handshake and forwarding.
// Define EX_MEM_SKID_EN for a second (skid) slot and registered ex_ready.
module ex_mem_reg
   import ex_mem_reg_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   ex_valid,
   output logic   ex_ready,
   input  data_t  alu_result,
   input  logic   rd_wren,
   input  data_t  pc,
   input  data_t  rs2,
   input  instr_t instr,
   input  logic   flush,
   output logic   mem_valid,
   input  logic   mem_ready,
   output data_t  mem_alu_result,
   output data_t  mem_pc,
   output data_t  mem_rs2,
   output instr_t mem_instr,
   output logic   mem_rd_wren,
   output data_t  ex_ex_fwd_data,
   output logic [4:0] fwd_rd,
   output logic   fwd_valid
);

   state_e state_q;
   state_e state_d;
   entry_t in_entry;
   entry_t out_entry;
   entry_t out_d;
   logic   accept;
   logic   transfer;
   logic   load_out;
   logic   clear_out;

   assign in_entry = '{
      alu_result: alu_result,
      pc:         pc,
      rs2:        rs2,
      instr:      instr,
      rd_wren:    rd_wren
   };

   assign mem_valid = (state_q != EMPTY);
   assign transfer  = mem_valid && mem_ready;
   assign accept    = ex_valid && ex_ready;

`ifdef EX_MEM_SKID_EN

   entry_t skid_entry;
   logic   ex_ready_q;
   logic   ex_ready_d;
   logic   load_skid;
   logic   clear_skid;
   logic   sel_skid;

   // Next state and slot controls; flush overrides everything.
   always_comb begin
      state_d    = state_q;
      load_out   = 1'b0;
      clear_out  = 1'b0;
      load_skid  = 1'b0;
      clear_skid = 1'b0;
      sel_skid   = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d  = FULL;
               load_out = 1'b1;
            end
         end
         FULL: begin
            if (accept && transfer) begin
               load_out = 1'b1;
            end else if (accept) begin
               state_d   = SKID;
               load_skid = 1'b1;
            end else if (transfer) begin
               state_d = EMPTY;
            end
         end
         SKID: begin
            if (transfer) begin
               state_d    = FULL;
               load_out   = 1'b1;
               sel_skid   = 1'b1;
               clear_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d    = EMPTY;
         load_out   = 1'b0;
         load_skid  = 1'b0;
         sel_skid   = 1'b0;
         clear_out  = 1'b1;
         clear_skid = 1'b1;
      end
      ex_ready_d = (state_d != SKID);
   end

   // State and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         ex_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         ex_ready_q <= ex_ready_d;
      end
   end

   assign ex_ready = ex_ready_q;
   assign out_d    = sel_skid ? skid_entry : in_entry;

   ex_mem_slot u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_skid),
      .clear_i (clear_skid),
      .d_i     (in_entry),
      .q_o     (skid_entry)
   );

`else

   // Next state and slot controls; flush overrides everything.
   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      clear_out = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d  = FULL;
               load_out = 1'b1;
            end
         end
         FULL: begin
            if (accept) begin
               load_out = 1'b1;
            end else if (transfer) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d   = EMPTY;
         load_out  = 1'b0;
         clear_out = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign ex_ready = !mem_valid || mem_ready;
   assign out_d    = in_entry;

`endif

   ex_mem_slot u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_out),
      .clear_i (clear_out),
      .d_i     (out_d),
      .q_o     (out_entry)
   );

   assign mem_alu_result = out_entry.alu_result;
   assign mem_pc         = out_entry.pc;
   assign mem_rs2        = out_entry.rs2;
   assign mem_instr      = out_entry.instr;
   assign mem_rd_wren    = out_entry.rd_wren;

   assign ex_ex_fwd_data = out_entry.alu_result;
   assign fwd_rd         = rd_of(out_entry.instr);
   assign fwd_valid      = mem_valid && mem_rd_wren
                         && (fwd_rd != 5'd0);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg.
// Works for both builds (EX_MEM_SKID_EN defined or not).
module tb_ex_mem_reg;
   import ex_mem_reg_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       ex_valid;
   logic       ex_ready;
   data_t      alu_result;
   logic       rd_wren;
   data_t      pc;
   data_t      rs2;
   instr_t     instr;
   logic       flush;
   logic       mem_valid;
   logic       mem_ready;
   data_t      mem_alu_result;
   data_t      mem_pc;
   data_t      mem_rs2;
   instr_t     mem_instr;
   logic       mem_rd_wren;
   data_t      ex_ex_fwd_data;
   logic [4:0] fwd_rd;
   logic       fwd_valid;

   int n_tests;
   int n_fail;

   ex_mem_reg dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .alu_result     (alu_result),
      .rd_wren        (rd_wren),
      .pc             (pc),
      .rs2            (rs2),
      .instr          (instr),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_alu_result (mem_alu_result),
      .mem_pc         (mem_pc),
      .mem_rs2        (mem_rs2),
      .mem_instr      (mem_instr),
      .mem_rd_wren    (mem_rd_wren),
      .ex_ex_fwd_data (ex_ex_fwd_data),
      .fwd_rd         (fwd_rd),
      .fwd_valid      (fwd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef EX_MEM_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   // Reference model: a FIFO of in-flight entries.
   typedef struct {
      data_t  alu;
      data_t  pc;
      data_t  rs2;
      instr_t ins;
      logic   wren;
   } m_ent_t;

   m_ent_t mq[$];

   function automatic logic m_ready();
      if (CAP == 2) return mq.size() < 2;
      return (mq.size() == 0) || mem_ready;
   endfunction

   task automatic model_step();
      logic rdy;
      logic xfer;
      m_ent_t e;
      rdy  = m_ready();
      xfer = (mq.size() > 0) && mem_ready;
      if (flush) begin
         mq.delete();
      end else begin
         if (xfer) void'(mq.pop_front());
         if (ex_valid && rdy) begin
            e.alu  = alu_result;
            e.pc   = pc;
            e.rs2  = rs2;
            e.ins  = instr;
            e.wren = rd_wren;
            mq.push_back(e);
         end
      end
   endtask

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic v;
      v = mq.size() > 0;
      chk("rnd_mem_valid", 32'(mem_valid), 32'(v));
      chk("rnd_ex_ready", 32'(ex_ready), 32'(m_ready()));
      if (v) begin
         chk("rnd_alu", mem_alu_result, mq[0].alu);
         chk("rnd_pc", mem_pc, mq[0].pc);
         chk("rnd_rs2", mem_rs2, mq[0].rs2);
         chk("rnd_instr", mem_instr, mq[0].ins);
         chk("rnd_wren", 32'(mem_rd_wren), 32'(mq[0].wren));
         chk("rnd_fwd_data", ex_ex_fwd_data, mq[0].alu);
         chk("rnd_fwd_rd", 32'(fwd_rd), 32'(mq[0].ins[11:7]));
         chk("rnd_fwd_valid", 32'(fwd_valid),
             32'(mq[0].wren && (mq[0].ins[11:7] != 5'd0)));
      end else begin
         chk("rnd_fwd_valid_idle", 32'(fwd_valid), 32'd0);
      end
   endtask

   function automatic instr_t mk_instr(input logic [4:0] rd);
      return {20'h0, rd, 7'h33};
   endfunction

   task automatic idle_inputs();
      ex_valid   = 1'b0;
      flush      = 1'b0;
      mem_ready  = 1'b0;
      alu_result = '0;
      pc         = '0;
      rs2        = '0;
      instr      = NOP;
      rd_wren    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      mq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       ev;
      data_t      alu;
      logic       wren;
      instr_t     ins;
      logic       mr;
      logic       fl;
      logic       e_mv;
      data_t      e_alu;
      logic       e_fv;
      logic [4:0] e_rd;
      logic       e_rdy;
      logic       cd;
   } vec_t;

   vec_t tbl[8];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b1;
      idle_inputs();

      // Vectors with mem_ready held high: same in both builds.
      tbl[0] = '{1'b1, 32'h1234, 1'b1, mk_instr(5'd5), 1'b1, 1'b0,
                 1'b1, 32'h1234, 1'b1, 5'd5, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 32'hA, 1'b1, mk_instr(5'd0), 1'b1, 1'b0,
                 1'b1, 32'hA, 1'b0, 5'd0, 1'b1, 1'b1};
      tbl[2] = '{1'b1, 32'hB, 1'b0, mk_instr(5'd5), 1'b1, 1'b0,
                 1'b1, 32'hB, 1'b0, 5'd5, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 32'h0, 1'b0, NOP, 1'b1, 1'b0,
                 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 32'hC, 1'b1, mk_instr(5'd31), 1'b1, 1'b0,
                 1'b1, 32'hC, 1'b1, 5'd31, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 32'hD, 1'b1, mk_instr(5'd3), 1'b1, 1'b1,
                 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 32'hE, 1'b1, mk_instr(5'd7), 1'b1, 1'b0,
                 1'b1, 32'hE, 1'b1, 5'd7, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 32'h0, 1'b0, NOP, 1'b1, 1'b0,
                 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0};

      // Reset values, checked before any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
      chk("rst_alu", mem_alu_result, 32'd0);
      chk("rst_pc", mem_pc, 32'd0);
      chk("rst_rs2", mem_rs2, 32'd0);
      chk("rst_instr", mem_instr, NOP);
      chk("rst_wren", 32'(mem_rd_wren), 32'd0);
      chk("rst_fwd_data", ex_ex_fwd_data, 32'd0);
      chk("rst_ex_ready", 32'(ex_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table vectors.
      foreach (tbl[i]) begin
         ex_valid   = tbl[i].ev;
         alu_result = tbl[i].alu;
         rd_wren    = tbl[i].wren;
         instr      = tbl[i].ins;
         mem_ready  = tbl[i].mr;
         flush      = tbl[i].fl;
         pc         = 32'h100 + 32'(i * 4);
         rs2        = 32'hF000 + 32'(i);
         tick();
         chk("tbl_mem_valid", 32'(mem_valid), 32'(tbl[i].e_mv));
         chk("tbl_fwd_valid", 32'(fwd_valid), 32'(tbl[i].e_fv));
         chk("tbl_ex_ready", 32'(ex_ready), 32'(tbl[i].e_rdy));
         if (tbl[i].cd) begin
            chk("tbl_alu", mem_alu_result, tbl[i].e_alu);
            chk("tbl_fwd_data", ex_ex_fwd_data, tbl[i].e_alu);
            chk("tbl_fwd_rd", 32'(fwd_rd), 32'(tbl[i].e_rd));
            chk("tbl_pc", mem_pc, 32'h100 + 32'(i * 4));
         end
      end

`ifdef EX_MEM_SKID_EN
      // Two accepts into a stalled output: skid fills.
      do_reset();
      ex_valid   = 1'b1;
      alu_result = 32'hA;
      tick();
      alu_result = 32'hB;
      tick();
      ex_valid = 1'b0;
      chk("skid_ex_ready", 32'(ex_ready), 32'd0);
      chk("skid_hold_a", mem_alu_result, 32'hA);
      tick();
      chk("skid_hold_a2", mem_alu_result, 32'hA);
      mem_ready = 1'b1;
      #1;
      chk("skid_out_a", mem_alu_result, 32'hA);
      tick();
      chk("skid_out_b_v", 32'(mem_valid), 32'd1);
      chk("skid_out_b", mem_alu_result, 32'hB);
      chk("skid_ready_back", 32'(ex_ready), 32'd1);
      tick();
      chk("skid_drained", 32'(mem_valid), 32'd0);

      // Flush while in SKID with a new entry offered.
      mem_ready  = 1'b0;
      ex_valid   = 1'b1;
      alu_result = 32'hC;
      tick();
      alu_result = 32'hD;
      tick();
      chk("skid2_ex_ready", 32'(ex_ready), 32'd0);
      flush      = 1'b1;
      alu_result = 32'hE;
      tick();
      flush     = 1'b0;
      ex_valid  = 1'b0;
      mem_ready = 1'b1;
      chk("flush_mem_valid", 32'(mem_valid), 32'd0);
      chk("flush_ex_ready", 32'(ex_ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("flush_no_out", 32'(mem_valid), 32'd0);
      end
`else
      // Combinational ready follows mem_ready in the same cycle.
      do_reset();
      ex_valid   = 1'b1;
      alu_result = 32'h55;
      tick();
      ex_valid = 1'b0;
      chk("comb_valid", 32'(mem_valid), 32'd1);
      chk("comb_ready_lo", 32'(ex_ready), 32'd0);
      mem_ready = 1'b1;
      #1;
      chk("comb_ready_hi", 32'(ex_ready), 32'd1);
      tick();
      chk("comb_drained", 32'(mem_valid), 32'd0);

      // Flush while stalled with a new entry offered.
      mem_ready  = 1'b0;
      ex_valid   = 1'b1;
      alu_result = 32'h66;
      tick();
      flush      = 1'b1;
      alu_result = 32'h77;
      tick();
      flush    = 1'b0;
      ex_valid = 1'b0;
      chk("flush_mem_valid", 32'(mem_valid), 32'd0);
      chk("flush_ex_ready", 32'(ex_ready), 32'd1);
      tick();
      chk("flush_no_out", 32'(mem_valid), 32'd0);
`endif

      // Asynchronous reset in the middle of a stall.
      do_reset();
      ex_valid   = 1'b1;
      alu_result = 32'h99;
      instr      = mk_instr(5'd9);
      rd_wren    = 1'b1;
      tick();
      ex_valid = 1'b0;
      chk("stall_fwd_valid", 32'(fwd_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_mem_valid", 32'(mem_valid), 32'd0);
      chk("arst_instr", mem_instr, NOP);
      chk("arst_fwd_valid", 32'(fwd_valid), 32'd0);
      chk("arst_alu", mem_alu_result, 32'd0);
      chk("arst_ex_ready", 32'(ex_ready), 32'd1);
      mq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic against the FIFO model.
      for (int i = 0; i < 600; i++) begin
         ex_valid   = ($urandom_range(0, 3) != 0);
         alu_result = $urandom;
         pc         = $urandom;
         rs2        = $urandom;
         instr      = $urandom;
         if ($urandom_range(0, 3) == 0) instr[11:7] = 5'd0;
         rd_wren    = 1'($urandom_range(0, 1));
         mem_ready  = ($urandom_range(0, 99) < (i < 300 ? 70 : 30));
         flush      = ($urandom_range(0, 19) == 0);
         #2;
         check_model();
         @(posedge clk);
         model_step();
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
